// File: rtl/mtm_alu_deserializer_if.sv
// Serial-in / parallel-out bundle between the sin driver and the ALU deserializer.
// master drives sin; slave (the deserializer) returns the decoded transaction.
interface mtm_alu_deserializer_if;
    logic        sin;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  op_o;
    logic [2:0]  err_o;
    logic        valid_o;

    modport master (
        output sin,
        input  a_o, b_o, op_o, err_o, valid_o
    );

    modport slave (
        input  sin,
        output a_o, b_o, op_o, err_o, valid_o
    );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// Parses 11-bit serial frames into operands A/B and an op code, checks CRC4,
// and emits one classified transaction per CTL frame as a one-cycle valid pulse.
module mtm_alu_deserializer #(
    parameter int DATA_FRAMES = 8,
    parameter bit CHECK_STOP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mtm_alu_deserializer_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TYPE = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] STOP = 2'd3;

    logic [1:0]  state_reg;
    logic [2:0]  bit_cnt_reg;
    logic        type_reg;
    logic [7:0]  byte_reg;
    logic [63:0] data_reg;
    logic [3:0]  count_reg;
    logic        framing_reg;

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [2:0]  op_reg;
    logic [2:0]  err_reg;
    logic        valid_reg;

    logic [3:0]  crc_calc;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic [2:0]  err_next;

    // Serial LFSR for x^4+x+1, zero init, fed MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] bits);
        logic [3:0] crc;
        logic       fb;
        crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ bits[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    always_comb begin
        crc_calc = crc4({data_reg, 1'b1, byte_reg[6:4]});
        err_data = (count_reg != 4'(DATA_FRAMES)) || framing_reg;
        err_crc  = (byte_reg[3:0] != crc_calc);
        err_op   = !(byte_reg[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
        err_next = 3'b000;
        if (err_data) begin
            err_next = 3'b100;
        end else if (err_crc) begin
            err_next = 3'b010;
        end else if (err_op) begin
            err_next = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            type_reg    <= 1'b0;
            byte_reg    <= 8'd0;
            data_reg    <= 64'd0;
            count_reg   <= 4'd0;
            framing_reg <= 1'b0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            op_reg      <= 3'd0;
            err_reg     <= 3'd0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!bus.sin) begin
                        state_reg <= TYPE;
                    end
                end
                TYPE: begin
                    type_reg    <= bus.sin;
                    bit_cnt_reg <= 3'd7;
                    state_reg   <= DATA;
                end
                DATA: begin
                    byte_reg    <= {byte_reg[6:0], bus.sin};
                    bit_cnt_reg <= bit_cnt_reg - 3'd1;
                    if (bit_cnt_reg == 3'd0) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    state_reg <= IDLE;
                    if (!bus.sin && CHECK_STOP) begin
                        framing_reg <= 1'b1;
                    end else if (!type_reg) begin
                        data_reg <= {data_reg[55:0], byte_reg};
                        if (count_reg != 4'd15) begin
                            count_reg <= count_reg + 4'd1;
                        end
                    end else begin
                        // Operands are published even on error; the consumer keys off err_o.
                        b_reg       <= data_reg[63:32];
                        a_reg       <= data_reg[31:0];
                        op_reg      <= byte_reg[6:4];
                        err_reg     <= err_next;
                        valid_reg   <= 1'b1;
                        count_reg   <= 4'd0;
                        framing_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.a_o     = a_reg;
    assign bus.b_o     = b_reg;
    assign bus.op_o    = op_reg;
    assign bus.err_o   = err_reg;
    assign bus.valid_o = valid_reg;

endmodule
